// File: rtl/mul_sequencer_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mul_sequencer_if : request/result bundle between decode and the multiplier
// Revision 1.0
// ----------------------------------------------------------------------------
interface mul_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       mulop;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             stall;
  logic             busy;
  logic             done;
  logic             illegal;
  logic [WIDTH-1:0] result_lo;
  logic [WIDTH-1:0] result_hi;

  modport master (
    output start, mulop, a, b,
    input  stall, busy, done, illegal, result_lo, result_hi
  );

  modport slave (
    input  start, mulop, a, b,
    output stall, busy, done, illegal, result_lo, result_hi
  );
endinterface
`default_nettype wire

// File: rtl/mul_sequencer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mul_sequencer : radix-2 shift-add multiply controller (MUL / UMULL / SMULL)
// Revision 1.0
// ----------------------------------------------------------------------------
module mul_sequencer #(
  parameter int WIDTH = 32
) (
  input  wire logic           clk,
  input  wire logic           reset,
  mul_sequencer_if.slave      bus
);

  localparam int         CW       = $clog2(WIDTH + 1);
  localparam logic [2:0] OP_MUL   = 3'b000;
  localparam logic [2:0] OP_UMULL = 3'b100;
  localparam logic [2:0] OP_SMULL = 3'b110;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                 r_state;
  logic [2*WIDTH-1:0]     r_mcand;
  logic [WIDTH-1:0]       r_mplier;
  logic [2*WIDTH-1:0]     r_acc;
  logic [CW-1:0]          r_cnt;
  logic [2:0]             r_op;
  logic                   r_sign;
  logic                   r_busy;
  logic                   r_done;
  logic                   r_illegal;
  logic [WIDTH-1:0]       r_lo;
  logic [WIDTH-1:0]       r_hi;

  logic                   w_legal;
  logic                   w_can_accept;
  logic                   w_accept;
  logic                   w_stall;
  logic                   w_is_smull;
  logic [WIDTH-1:0]       w_mag_a;
  logic [WIDTH-1:0]       w_mag_b;
  logic [2*WIDTH-1:0]     w_addend;
  logic [2*WIDTH-1:0]     w_acc_next;
  logic [2*WIDTH-1:0]     w_prod;

  always_comb begin
    w_legal      = (bus.mulop == OP_MUL) || (bus.mulop == OP_UMULL) ||
                   (bus.mulop == OP_SMULL);
    w_can_accept = (r_state == S_IDLE) || (r_state == S_DONE);
    w_accept     = bus.start && w_legal && w_can_accept;
    w_stall      = w_accept || (r_state == S_RUN);
    w_is_smull   = (bus.mulop == OP_SMULL);
    // Negating the most-negative value yields itself, which read unsigned is the right magnitude.
    w_mag_a      = (w_is_smull && bus.a[WIDTH-1]) ? -bus.a : bus.a;
    w_mag_b      = (w_is_smull && bus.b[WIDTH-1]) ? -bus.b : bus.b;
    w_addend     = r_mplier[0] ? r_mcand : '0;
    w_acc_next   = r_acc + w_addend;
    w_prod       = r_sign ? -w_acc_next : w_acc_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_mcand   <= '0;
      r_mplier  <= '0;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_op      <= OP_MUL;
      r_sign    <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_illegal <= 1'b0;
      r_lo      <= '0;
      r_hi      <= '0;
    end else begin
      r_done    <= 1'b0;
      r_illegal <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE: begin
          if (bus.start && !w_legal) begin
            r_illegal <= 1'b1;
          end
          if (w_accept) begin
            r_state  <= S_RUN;
            r_busy   <= 1'b1;
            r_mcand  <= {{WIDTH{1'b0}}, w_mag_a};
            r_mplier <= w_mag_b;
            r_acc    <= '0;
            r_cnt    <= CW'(WIDTH);
            r_op     <= bus.mulop;
            r_sign   <= w_is_smull && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
          end else begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end
        S_RUN: begin
          r_acc    <= w_acc_next;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt - CW'(1);
          if (r_cnt == CW'(1)) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_lo    <= w_prod[WIDTH-1:0];
            r_hi    <= (r_op == OP_MUL) ? '0 : w_prod[2*WIDTH-1:WIDTH];
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.stall     = w_stall;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.illegal   = r_illegal;
  assign bus.result_lo = r_lo;
  assign bus.result_hi = r_hi;

endmodule
`default_nettype wire

// File: tb/tb_mul_sequencer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_mul_sequencer : scoreboard bench for mul_sequencer with a 64-bit reference
// Revision 1.0
// ----------------------------------------------------------------------------
module tb_mul_sequencer;

  localparam logic [2:0] OP_MUL   = 3'b000;
  localparam logic [2:0] OP_UMULL = 3'b100;
  localparam logic [2:0] OP_SMULL = 3'b110;

  typedef struct {
    int          due;
    logic [31:0] lo;
    logic [31:0] hi;
    string       name;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  exp_t sb[$];
  logic [31:0] last_lo = '0;
  logic [31:0] last_hi = '0;

  mul_sequencer_if #(.WIDTH(32)) bus ();

  mul_sequencer #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [63:0] ref_prod(input logic [2:0] op, input logic [31:0] x,
                                           input logic [31:0] y);
    logic signed [63:0] sx;
    logic signed [63:0] sy;
    logic [31:0]        lo32;
    case (op)
      OP_MUL: begin
        lo32 = x * y;
        return {32'd0, lo32};
      end
      OP_UMULL: return {32'd0, x} * {32'd0, y};
      default: begin
        sx = {{32{x[31]}}, x};
        sy = {{32{y[31]}}, y};
        return sx * sy;
      end
    endcase
  endfunction

  // Monitor: every done pulse must match the oldest outstanding request
  always @(negedge clk) begin
    if (!reset && bus.done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk({e.name, "_lo"}, 64'(bus.result_lo), 64'(e.lo));
        chk({e.name, "_hi"}, 64'(bus.result_hi), 64'(e.hi));
        chk({e.name, "_latency"}, 64'(cyc), 64'(e.due));
      end
    end
  end

  // Called just after a falling edge; returns after the accepting edge.
  task automatic issue(input string name, input logic [2:0] op, input logic [31:0] x,
                       input logic [31:0] y);
    logic [63:0] p;
    exp_t        e;
    bus.start = 1'b1; bus.mulop = op; bus.a = x; bus.b = y;
    #1;
    chk({name, "_stall_req"}, 64'(bus.stall), 64'd1);
    @(posedge clk); #1;
    p = ref_prod(op, x, y);
    e.due = cyc + 32; e.lo = p[31:0]; e.hi = p[63:32]; e.name = name;
    sb.push_back(e);
    last_lo = p[31:0]; last_hi = p[63:32];
    chk({name, "_busy"}, 64'(bus.busy), 64'd1);
    bus.start = 1'b0; bus.a = $urandom; bus.b = $urandom; bus.mulop = 3'($urandom);
  endtask

  task automatic wait_done(input bit toggle, output int stall_hi, output bit ok);
    stall_hi = 0;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.done) begin
        bus.start = 1'b0;
        #1;
        ok = 1'b1;
        break;
      end
      if (bus.stall) stall_hi++;
      if (toggle) begin
        bus.start = 1'($urandom_range(0, 1));
        bus.mulop = 3'($urandom);
        bus.a = $urandom; bus.b = $urandom;
      end
    end
  endtask

  task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] x,
                        input logic [31:0] y, input bit toggle);
    int sh;
    bit ok;
    issue(name, op, x, y);
    wait_done(toggle, sh, ok);
    chk({name, "_timeout"}, 64'(ok), 64'd1);
    chk({name, "_stall_run"}, 64'(sh), 64'd32);
    chk({name, "_stall_done"}, 64'(bus.stall), 64'd0);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'h0000_0001;
      2: return 32'h8000_0000;
      3: return 32'hFFFF_FFFF;
      4: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int  sh;
    int  drops;
    bit  ok;
    bit  got;
    exp_t e;
    logic [2:0] ops [3];
    ops[0] = OP_MUL; ops[1] = OP_UMULL; ops[2] = OP_SMULL;

    bus.start = 1'b0; bus.mulop = 3'b000; bus.a = '0; bus.b = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_illegal", 64'(bus.illegal), 64'd0);
    chk("rst_lo", 64'(bus.result_lo), 64'd0);
    chk("rst_hi", 64'(bus.result_hi), 64'd0);
    chk("rst_stall", 64'(bus.stall), 64'd0);

    @(negedge clk);
    run_op("umull_max", OP_UMULL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    @(negedge clk);
    run_op("smull_m3x5", OP_SMULL, 32'hFFFF_FFFD, 32'd5, 1'b0);
    @(negedge clk);
    run_op("smull_minmin", OP_SMULL, 32'h8000_0000, 32'h8000_0000, 1'b0);
    @(negedge clk);
    run_op("smull_m1m1", OP_SMULL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    @(negedge clk);
    run_op("mul_shift", OP_MUL, 32'h1234_5678, 32'h10, 1'b0);
    @(negedge clk);
    run_op("mul_max", OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);

    // Back-to-back: second request held during RUN, accepted in the DONE cycle
    @(negedge clk);
    issue("b2b_first", OP_UMULL, $urandom, $urandom);
    e = sb[sb.size()-1];
    bus.start = 1'b1; bus.mulop = OP_UMULL; bus.a = 32'd7; bus.b = 32'd6;
    drops = 0; got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!bus.stall) drops++;
      if (bus.done) begin got = 1'b1; break; end
    end
    chk("b2b_first_timeout", 64'(got), 64'd1);
    @(posedge clk); #1;
    e.due = e.due + 33; e.lo = 32'd42; e.hi = 32'd0; e.name = "b2b_second";
    sb.push_back(e);
    last_lo = 32'd42; last_hi = 32'd0;
    bus.start = 1'b0;
    wait_done(1'b0, sh, ok);
    chk("b2b_second_timeout", 64'(ok), 64'd1);
    chk("b2b_second_stall_run", 64'(sh), 64'd32);
    chk("b2b_stall_drops", 64'(drops), 64'd0);

    // Illegal op: pulse only, nothing else moves
    @(negedge clk);
    bus.start = 1'b1; bus.mulop = 3'b010; bus.a = $urandom; bus.b = $urandom;
    #1;
    chk("ill_stall_req", 64'(bus.stall), 64'd0);
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk("ill_pulse", 64'(bus.illegal), 64'd1);
    chk("ill_busy", 64'(bus.busy), 64'd0);
    chk("ill_stall", 64'(bus.stall), 64'd0);
    @(negedge clk);
    @(posedge clk); #1;
    chk("ill_pulse_end", 64'(bus.illegal), 64'd0);
    chk("ill_lo_kept", 64'(bus.result_lo), 64'(last_lo));
    chk("ill_hi_kept", 64'(bus.result_hi), 64'(last_hi));

    // start and operands churn during RUN
    @(negedge clk);
    run_op("toggle_run", OP_SMULL, $urandom, $urandom, 1'b1);

    // Reset in the middle of RUN
    @(negedge clk);
    issue("rst_mid", OP_UMULL, $urandom, $urandom);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    sb.delete();
    chk("midrst_busy", 64'(bus.busy), 64'd0);
    chk("midrst_done", 64'(bus.done), 64'd0);
    chk("midrst_lo", 64'(bus.result_lo), 64'd0);
    chk("midrst_hi", 64'(bus.result_hi), 64'd0);
    chk("midrst_stall", 64'(bus.stall), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (40) @(negedge clk);
    run_op("after_rst", OP_UMULL, 32'd3, 32'd4, 1'b0);

    // Randomized legal ops with corner operands mixed in
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      run_op($sformatf("rnd%0d", n), ops[$urandom_range(0, 2)], pick(), pick(), n[0]);
    end

    repeat (3) @(negedge clk);
    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
